// File: rtl/regfile_wb_pkg.sv
// Shared types and the partial-width merge helper for the regfile_wb writeback unit.
// The merge works on a 64-bit container, so XLEN up to 64 is supported.
package regfile_wb_pkg;

  typedef enum logic [1:0] {
    SRC_DIN = 2'd0,
    SRC_RET = 2'd1,
    SRC_IMM = 2'd2,
    SRC_ALU = 2'd3
  } wb_src_t;

  typedef enum logic [1:0] {
    W_BYTE  = 2'd0,
    W_HALF  = 2'd1,
    W_WORD  = 2'd2,
    W_DWORD = 2'd3
  } width_t;

  localparam int MERGE_W = 64;

  // Low bytes come from new_val, upper bits keep old_val.
  function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0] old_val,
                                               input logic [MERGE_W-1:0] new_val,
                                               input width_t             width);
    logic [MERGE_W-1:0] res;
    res = old_val;
    case (width)
      W_BYTE:  res[7:0]  = new_val[7:0];
      W_HALF:  res[15:0] = new_val[15:0];
      W_WORD:  res[31:0] = new_val[31:0];
      default: res       = new_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Writeback, load-return and operand-read bus between the pipeline and regfile_wb.
interface regfile_wb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 16,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                 wr;
  logic [1:0]           wr_src;
  logic                 setr;
  logic [AW-1:0]        wrsel;
  logic [1:0]           width;
  logic [XLEN-1:0]      din;
  logic [XLEN-1:0]      retaddr;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      aluout;
  logic                 wr_ack;

  logic                 ld_issue;
  logic [AW-1:0]        ld_rd;
  logic                 ld_ret;
  logic [AW-1:0]        ld_ret_rd;
  logic [XLEN-1:0]      ld_data;

  logic [NRD*AW-1:0]    rdsel;
  logic [NRD*XLEN-1:0]  rdout;
  logic [NRD-1:0]       rd_busy;

  modport master (
    output wr, wr_src, setr, wrsel, width, din, retaddr, imm, aluout,
    output ld_issue, ld_rd, ld_ret, ld_ret_rd, ld_data, rdsel,
    input  wr_ack, rdout, rd_busy
  );

  modport slave (
    input  wr, wr_src, setr, wrsel, width, din, retaddr, imm, aluout,
    input  ld_issue, ld_rd, ld_ret, ld_ret_rd, ld_data, rdsel,
    output wr_ack, rdout, rd_busy
  );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// Load scoreboard: one busy bit per register, set on load issue, cleared on load return.
module regfile_scoreboard #(
  parameter  int NREGS = 16,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_issue,
  input  logic [AW-1:0]     ld_rd,
  input  logic              ld_ret,
  input  logic [AW-1:0]     ld_ret_rd,
  input  logic [NRD*AW-1:0] rdsel,
  input  logic [AW-1:0]     wrsel,
  output logic [NRD-1:0]    rd_busy,
  output logic              wr_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (ld_issue) set_mask[ld_rd]     = 1'b1;
    if (ld_ret)   clr_mask[ld_ret_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle issue/return keeps the register busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= (busy & ~clr_mask) | set_mask;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) rd_busy[i] = busy[rdsel[i*AW +: AW]];
  end

  assign wr_busy = busy[wrsel];

endmodule

// File: rtl/regfile_wb.sv
// Register file with muxed writeback source, partial-width merge, one-stage writeback register
// and load scoreboard. REGFILE_WB_BYPASS_EN enables read bypass from the writeback register.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 16,
  parameter int NRD   = 2
) (
  input logic         clk,
  input logic         reset,
  regfile_wb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            wb_v;
  logic [AW-1:0]   wb_sel;
  logic [XLEN-1:0] wb_data;

  logic [NRD-1:0]  sb_busy;
  logic            wr_busy;
  logic            suppressed;
  logic            eff_req;
  logic            wr_take;
  wb_src_t         src;
  logic [XLEN-1:0] src_val;
  logic [XLEN-1:0] base_val;
  logic [XLEN-1:0] merged;

  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .ld_issue  (bus.ld_issue),
    .ld_rd     (bus.ld_rd),
    .ld_ret    (bus.ld_ret),
    .ld_ret_rd (bus.ld_ret_rd),
    .rdsel     (bus.rdsel),
    .wrsel     (bus.wrsel),
    .rd_busy   (sb_busy),
    .wr_busy   (wr_busy)
  );

  assign src        = wb_src_t'(bus.wr_src);
  assign suppressed = bus.wr & (src == SRC_ALU) & ~bus.setr;
  assign eff_req    = bus.wr & ~suppressed;

  // A suppressed ALU write is acknowledged regardless of port conflicts since it changes nothing.
  assign bus.wr_ack = reset & bus.wr & (suppressed | (~bus.ld_ret & ~wr_busy));
  assign wr_take    = eff_req & bus.wr_ack;

  always_comb begin
    case (src)
      SRC_DIN: src_val = bus.din;
      SRC_RET: src_val = bus.retaddr;
      SRC_IMM: src_val = bus.imm;
      default: src_val = bus.aluout;
    endcase
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign base_val = (wb_v && wb_sel == bus.wrsel) ? wb_data : regs[bus.wrsel];
`else
  assign base_val = regs[bus.wrsel];
`endif

  assign merged = XLEN'(merge(MERGE_W'(base_val), MERGE_W'(src_val), width_t'(bus.width)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_v    <= 1'b0;
      wb_sel  <= '0;
      wb_data <= '0;
    end else if (bus.ld_ret) begin
      wb_v    <= 1'b1;
      wb_sel  <= bus.ld_ret_rd;
      wb_data <= bus.ld_data;
    end else if (wr_take) begin
      wb_v    <= 1'b1;
      wb_sel  <= bus.wrsel;
      wb_data <= merged;
    end else begin
      wb_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_v) begin
      regs[wb_sel] <= wb_data;
    end
  end

  always_comb begin
    bus.rdout   = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_v && wb_sel == bus.rdsel[i*AW +: AW])
        bus.rdout[i*XLEN +: XLEN] = wb_data;
      else
        bus.rdout[i*XLEN +: XLEN] = regs[bus.rdsel[i*AW +: AW]];
      bus.rd_busy[i] = sb_busy[i];
`else
      // No bypass: a register still in the writeback stage reads as busy for one cycle.
      bus.rdout[i*XLEN +: XLEN] = regs[bus.rdsel[i*AW +: AW]];
      bus.rd_busy[i] = sb_busy[i] | (wb_v && wb_sel == bus.rdsel[i*AW +: AW]);
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed vector table, hand sequences, random vs reference model.
module tb_regfile_wb;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_if #(.XLEN(64), .NREGS(16), .NRD(2)) bus ();
  regfile_wb #(.XLEN(64), .NREGS(16), .NRD(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;  logic [1:0] src; logic setr; logic [3:0] wsel; logic [1:0] wd; logic [63:0] data;
    logic        iss; logic [3:0] ird; logic ret;  logic [3:0] rrd;  logic [63:0] ldd;
    logic [3:0]  rs0; logic [3:0] rs1;
    logic        e_ack; logic [63:0] e_r0; logic e_b0; logic [63:0] e_r1; logic e_b1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [1:0] src, logic setr, logic [3:0] wsel, logic [1:0] wd,
                              logic [63:0] data, logic iss, logic [3:0] ird, logic ret, logic [3:0] rrd,
                              logic [63:0] ldd, logic [3:0] rs0, logic [3:0] rs1, logic e_ack,
                              logic [63:0] e_r0, logic e_b0, logic [63:0] e_r1, logic e_b1);
    vec_t v;
    v.wr = wr; v.src = src; v.setr = setr; v.wsel = wsel; v.wd = wd; v.data = data;
    v.iss = iss; v.ird = ird; v.ret = ret; v.rrd = rrd; v.ldd = ldd; v.rs0 = rs0; v.rs1 = rs1;
    v.e_ack = e_ack; v.e_r0 = e_r0; v.e_b0 = e_b0; v.e_r1 = e_r1; v.e_b1 = e_b1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  // Selected source carries data; the other sources carry distinct junk.
  task automatic drive(input logic wr, input logic [1:0] src, input logic setr, input logic [3:0] wsel,
                       input logic [1:0] wd, input logic [63:0] data, input logic iss, input logic [3:0] ird,
                       input logic ret, input logic [3:0] rrd, input logic [63:0] ldd,
                       input logic [3:0] rs0, input logic [3:0] rs1);
    bus.wr = wr; bus.wr_src = src; bus.setr = setr; bus.wrsel = wsel; bus.width = wd;
    bus.din     = (src == 2'd0) ? data : 64'hD0D0_D0D0_D0D0_D0D0;
    bus.retaddr = (src == 2'd1) ? data : 64'hE1E1_E1E1_E1E1_E1E1;
    bus.imm     = (src == 2'd2) ? data : 64'h1A1A_1A1A_1A1A_1A1A;
    bus.aluout  = (src == 2'd3) ? data : 64'hA1A1_A1A1_A1A1_A1A1;
    bus.ld_issue = iss; bus.ld_rd = ird; bus.ld_ret = ret; bus.ld_ret_rd = rrd; bus.ld_data = ldd;
    bus.rdsel = {rs1, rs0};
  endtask

  task automatic idle(input logic [3:0] rs0, input logic [3:0] rs1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rs0, rs1);
  endtask

  task automatic do_reset();
    idle(0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Reference model: logical register values, busy set, and the one write still in flight.
  logic [63:0] mval [16];
  logic [15:0] mbusy;
  logic        pv;
  logic [3:0]  preg;
  logic [63:0] pold;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mval[k] = '0;
    mbusy = '0; pv = 1'b0; preg = '0; pold = '0;
  endtask

  logic        r_wr, r_setr, r_iss, r_ret, supp, e_ack, e_b, npv;
  logic [1:0]  r_src, r_wd;
  logic [3:0]  r_wsel, r_ird, r_rrd, r_rs [2];
  logic [63:0] r_val [4], r_ldd, e_v, srcv, mask;
  int          bits;

  initial begin
    idle(0, 0);
    reset = 1'b0;

    // Reset arriving while a write sits in the writeback register.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 3, 1, 3, 3, 64'h55, 1, 3, 0, 0, 0, 3, 3);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ack", 0, 64'(bus.wr_ack), 64'd0);
    chk("rst_busy", 0, 64'(bus.rd_busy), 64'd0);
    chk("rst_rdout", 0, bus.rdout[63:0], 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(3, 3);
    #1;
    chk("rst_r3", 1, bus.rdout[63:0], 64'd0);
    chk("rst_busy", 1, 64'(bus.rd_busy), 64'd0);
    @(negedge clk); #1;
    chk("rst_r3", 2, bus.rdout[63:0], 64'd0);

    // Directed vector table from a clean reset.
    do_reset();
    tbl.push_back(mk(1,3,1,5,3,ONES, 0,0,0,0,0, 5,2, 1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,2, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 5,2, 0, ONES,0, 0,0));
    tbl.push_back(mk(1,3,0,2,3,64'h99, 0,0,0,0,0, 2,5, 1, 0,0, ONES,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 2,0, 0, 0,0, 0,0));
    tbl.push_back(mk(1,3,1,2,3,64'h7, 0,0,0,0,0, 5,3, 1, ONES,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 2,5, 0, 64'h7,0, ONES,0));
    tbl.push_back(mk(0,0,0,0,0,0,    1,4,0,0,0, 4,2, 0, 0,0, 64'h7,0));
    tbl.push_back(mk(1,2,0,4,3,64'h1111, 0,0,0,0,0, 4,7, 0, 0,1, 0,0));
    tbl.push_back(mk(1,2,0,4,3,64'h1111, 0,0,1,4,64'hABCD, 4,2, 0, 0,1, 64'h7,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 1,2, 0, 0,0, 64'h7,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 4,4, 0, 64'hABCD,0, 64'hABCD,0));
    tbl.push_back(mk(1,0,0,6,3,64'h66, 0,0,1,1,64'h1234_5678_9ABC_DEF0, 6,1, 0, 0,0, 0,0));
    tbl.push_back(mk(1,0,0,6,3,64'h66, 0,0,0,0,0, 6,5, 1, 0,0, ONES,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 1,2, 0, 64'h1234_5678_9ABC_DEF0,0, 64'h7,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 6,4, 0, 64'h66,0, 64'hABCD,0));
    tbl.push_back(mk(0,0,0,0,0,0,    1,7,1,7,64'h77, 7,0, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 3,3, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 7,7, 0, 64'h77,1, 64'h77,1));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,1,7,64'h78, 7,0, 0, 64'h77,1, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 7,0, 0, 64'h78,0, 0,0));
    tbl.push_back(mk(1,1,0,8,2,64'hAAAA_BBBB_CCCC_DDDD, 0,0,0,0,0, 0,0, 1, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 8,0, 0, 64'hCCCC_DDDD,0, 0,0));
    tbl.push_back(mk(1,0,0,8,1,64'hFFFF_FFFF_FFFF_1234, 0,0,0,0,0, 8,0, 1, 64'hCCCC_DDDD,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0, 0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 8,0, 0, 64'hCCCC_1234,0, 0,0));
    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].wr, tbl[k].src, tbl[k].setr, tbl[k].wsel, tbl[k].wd, tbl[k].data, tbl[k].iss,
            tbl[k].ird, tbl[k].ret, tbl[k].rrd, tbl[k].ldd, tbl[k].rs0, tbl[k].rs1);
      #1;
      chk("tbl_ack", k, 64'(bus.wr_ack), 64'(tbl[k].e_ack));
      chk("tbl_rdout0", k, bus.rdout[63:0], tbl[k].e_r0);
      chk("tbl_busy0", k, 64'(bus.rd_busy[0]), 64'(tbl[k].e_b0));
      chk("tbl_rdout1", k, bus.rdout[127:64], tbl[k].e_r1);
      chk("tbl_busy1", k, 64'(bus.rd_busy[1]), 64'(tbl[k].e_b1));
    end

    // Byte merge onto an all-ones register, then read back immediately and after commit.
    do_reset();
    drive(1, 3, 1, 5, 3, ONES, 0, 0, 0, 0, 0, 0, 0);
`ifndef REGFILE_WB_BYPASS_EN
    @(negedge clk); idle(0, 0);
`endif
    @(negedge clk);
    drive(1, 2, 0, 5, 0, 64'h12, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("merge_ack", 0, 64'(bus.wr_ack), 64'd1);
    @(negedge clk);
    idle(5, 5);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("merge_bypass", 0, bus.rdout[63:0], 64'hFFFF_FFFF_FFFF_FF12);
    chk("merge_busy", 0, 64'(bus.rd_busy[0]), 64'd0);
`else
    chk("nobyp_stall", 0, 64'(bus.rd_busy[0]), 64'd1);
    @(negedge clk); #1;
    chk("nobyp_value", 0, bus.rdout[63:0], 64'hFFFF_FFFF_FFFF_FF12);
    chk("nobyp_busy", 0, 64'(bus.rd_busy[0]), 64'd0);
`endif
    repeat (2) @(negedge clk);
    #1 chk("merge_persist", 0, bus.rdout[127:64], 64'hFFFF_FFFF_FFFF_FF12);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      r_wr   = ($urandom_range(0, 3) != 0);
      r_src  = 2'($urandom_range(0, 3));
      r_setr = ($urandom_range(0, 3) != 0);
      r_wsel = 4'($urandom_range(0, 15));
      r_wd   = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) r_val[k] = {$urandom, $urandom};
      r_iss  = ($urandom_range(0, 3) == 0);
      r_ird  = 4'($urandom_range(0, 15));
      r_ret  = (mbusy != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      r_rrd  = 4'($urandom_range(0, 15));
      if (mbusy != 0 && $urandom_range(0, 3) != 0)
        for (int k = 0; k < 16; k++) if (!mbusy[r_rrd]) r_rrd = r_rrd + 4'd1;
      r_ldd  = {$urandom, $urandom};
      r_rs[0] = 4'($urandom_range(0, 15));
      r_rs[1] = 4'($urandom_range(0, 15));
`ifndef REGFILE_WB_BYPASS_EN
      if (pv && r_wsel == preg) r_wsel = r_wsel + 4'd1;
`endif
      bus.wr = r_wr; bus.wr_src = r_src; bus.setr = r_setr; bus.wrsel = r_wsel; bus.width = r_wd;
      bus.din = r_val[0]; bus.retaddr = r_val[1]; bus.imm = r_val[2]; bus.aluout = r_val[3];
      bus.ld_issue = r_iss; bus.ld_rd = r_ird; bus.ld_ret = r_ret; bus.ld_ret_rd = r_rrd;
      bus.ld_data = r_ldd; bus.rdsel = {r_rs[1], r_rs[0]};

      supp  = r_wr && r_src == 2'd3 && !r_setr;
      e_ack = r_wr && (supp || (!r_ret && !mbusy[r_wsel]));
      #1;
      chk("rnd_ack", c, 64'(bus.wr_ack), 64'(e_ack));
      for (int p = 0; p < 2; p++) begin
        e_v = mval[r_rs[p]];
        e_b = mbusy[r_rs[p]];
`ifndef REGFILE_WB_BYPASS_EN
        if (pv && preg == r_rs[p]) begin e_v = pold; e_b = 1'b1; end
`endif
        chk(p == 0 ? "rnd_rdout0" : "rnd_rdout1", c, bus.rdout[p*64 +: 64], e_v);
        chk(p == 0 ? "rnd_busy0" : "rnd_busy1", c, 64'(bus.rd_busy[p]), 64'(e_b));
      end

      npv = 1'b0;
      if (r_ret) begin
        pold = mval[r_rrd]; mval[r_rrd] = r_ldd; preg = r_rrd; npv = 1'b1;
      end else if (e_ack && !supp) begin
        srcv = r_val[r_src];
        bits = 8 << r_wd;
        mask = (bits >= 64) ? ONES : ((64'd1 << bits) - 64'd1);
        pold = mval[r_wsel];
        mval[r_wsel] = (mval[r_wsel] & ~mask) | (srcv & mask);
        preg = r_wsel; npv = 1'b1;
      end
      pv = npv;
      if (r_ret) mbusy[r_rrd] = 1'b0;
      if (r_iss) mbusy[r_ird] = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Parametrised register-file writeback unit: NREGS x XLEN storage with NRD read ports.
- Single write port fed by an encoded writeback-source mux (memory, return address, immediate, ALU).
- Partial-width merge writes, a one-stage writeback register with read bypass, and a load scoreboard that tracks outstanding memory loads and flags hazards to the issue stage.
- Sits between execute/memory stages and decode operand fetch in the t64 core.

Parameters:
- XLEN, 64, register width in bits.
- NREGS, 16, number of architectural registers; AW = $clog2(NREGS).
- NRD, 2, number of read ports.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- wr  input  1  pipeline writeback request.
- wr_src  input  2  source select: 0=DIN, 1=RET, 2=IMM, 3=ALU.
- setr  input  1  when wr_src=ALU, write is performed only if setr=1.
- wrsel  input  AW  destination register.
- width  input  2  0=byte, 1=half, 2=word, 3=dword.
- din, retaddr, imm, aluout  input  XLEN each  candidate write data.
- wr_ack  output  1  request accepted this cycle.
- ld_issue  input  1  load issued to memory; marks ld_rd busy.
- ld_rd  input  AW  load destination.
- ld_ret  input  1  load data returning on ld_data.
- ld_ret_rd  input  AW  returning load destination.
- ld_data  input  XLEN  load data; always written full width.
- rdsel  input  NRD*AW  packed read selects; port i = bits [i*AW +: AW].
- rdout  output  NRD*XLEN  packed read data.
- rd_busy  output  NRD  port i reads a register with an outstanding load.

Behaviour:
Reset (asynchronous, active-low):
- All registers, the writeback register (wb_v, wb_sel, wb_data) and the busy vector are cleared to 0.
- Outputs go to: wr_ack=0, rd_busy=0, rdout=0 (array is zero, nothing to bypass).
- A pending write in the writeback register is discarded, not committed.

Write acceptance (effective request = wr & ~(wr_src==ALU & ~setr)):
- ld_ret has priority for the write port; a pipeline request in the same cycle gets wr_ack=0 and must be held.
- A request whose wrsel is busy also gets wr_ack=0 (WAW ordering); it retries on later cycles.
- Otherwise wr_ack=1, combinationally in the same cycle.
- A suppressed ALU write (setr=0) gets wr_ack=1 with no state change.

Writeback pipeline:
- At the accepting edge, the merged value is captured in the writeback register (wb_v=1).
- Merge: the low 8/16/32/64 bits are replaced by the source; upper bits keep the current register value, taking bypass into account.
- A load return is always captured as a full-width ld_data write.
- The array is updated at the next edge, so a write takes 1 cycle to reach the array.
- Back-to-back writes to the same register chain through the bypass and merge correctly.

Reads (combinational):
- rdout[i] = wb_data if wb_v & wb_sel==rdsel[i], else array[rdsel[i]].

Scoreboard:
- ld_issue sets busy[ld_rd]; ld_ret clears busy[ld_ret_rd].
- If both hit the same register in one cycle, set wins.
- ld_ret to a non-busy register: data is still written, busy stays 0.
- rd_busy[i] = busy[rdsel[i]].

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: reads bypass from the writeback register as described above.
- Undefined: rdout comes from the array only, and rd_busy[i] additionally asserts when wb_v & wb_sel==rdsel[i], so the issue stage stalls for one cycle.
- Merge base then uses the array value, which is safe because a dependent write to a pending register must follow a stall.

Decomposition:
- Package regfile_wb_pkg holds:
  - wb_src_t enum (SRC_DIN, SRC_RET, SRC_IMM, SRC_ALU).
  - width_t enum (W_BYTE, W_HALF, W_WORD, W_DWORD).
  - A merge function (old, new, width) -> XLEN.
- One sub-module: regfile_scoreboard (busy vector, set/clear, per-port lookup).

Test Plan:
- Reset low mid-write (wr=1, ALU, r3=0x55) -> r3 reads 0 after release; wr_ack=0 and rd_busy=0 during reset.
- r5=0xFFFF_FFFF_FFFF_FFFF, then wr IMM 0x12 width=byte to r5 -> next cycle rdout=0xFFFF_FFFF_FFFF_FF12 via bypass; the value persists after commit.
- wr_src=ALU, setr=0, r2 -> wr_ack=1 and r2 unchanged; with setr=1, aluout=0x7 -> r2=0x7.
- ld_issue r4, then rdsel0=r4 -> rd_busy[0]=1; wr to r4 -> wr_ack=0 until ld_ret r4 with 0xABCD; afterwards r4=0xABCD and rd_busy=0.
- ld_ret r1 and wr r6 in the same cycle -> wr_ack=0; r1 written; r6 written the following cycle.
- ld_issue and ld_ret both on r7 in the same cycle -> busy[7] stays 1.
- Without REGFILE_WB_BYPASS_EN: write r9, read r9 next cycle -> rd_busy=1 for one cycle, then the correct value appears.
